reg_trace_capture: RTL and testbench

//  Multi-channel architectural-register trace unit for the MIPS32 pipeline system.

---
 rtl/reg_trace_capture.sv | 199 +++++++++++++++++++
 tb/tb_reg_trace_capture.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_trace_capture.sv
// Purpose : watches NUM_CH register taps, timestamps each value change and queues it for readout.
// Latency : tap change sampled at edge N is at the FIFO head after edge N+1 (empty FIFO, no contention).
// Backpres: o_out_valid/i_out_ready; FIFO full holds changes in per-channel slots, overwrites counted.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_tap_in            packed taps, channel k = i_tap_in[k*WIDTH +: WIDTH]
//   i_capture_en        1 = detect changes; 0 = taps ignored and previous values frozen
//   o_out_valid/i_out_ready  first-word-fall-through head handshake
//   o_out_ch/o_out_data/o_out_stamp  head entry (holds last popped entry when empty)
//   o_fifo_count        FIFO occupancy
//   o_overflow_cnt      saturating count of slot overwrites (lost events)
//   o_fib_err           sticky Fibonacci recurrence violation on channel-0 writes
module reg_trace_capture #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int STAMP_W   = 20,
  parameter int FIB_CHECK = 1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_CH*WIDTH-1:0] i_tap_in,
  input  logic                    i_capture_en,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [CW-1:0]           o_out_ch,
  output logic [WIDTH-1:0]        o_out_data,
  output logic [STAMP_W-1:0]      o_out_stamp,
  output logic [AW:0]             o_fifo_count,
  output logic [15:0]             o_overflow_cnt,
  output logic                    o_fib_err
);

  typedef struct packed {
    logic [CW-1:0]      ch;
    logic [WIDTH-1:0]   data;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  // Change detection and per-channel pending slots
  logic [WIDTH-1:0]   r_prev   [NUM_CH];
  logic [WIDTH-1:0]   r_sdata  [NUM_CH];
  logic [STAMP_W-1:0] r_sstamp [NUM_CH];
  logic [NUM_CH-1:0]  r_pend;
  logic [CW-1:0]      r_ptr;
  logic [STAMP_W-1:0] r_stamp;
  logic [15:0]        r_ovf;

  // FIFO state
  entry_t             r_mem [DEPTH];
  logic [AW-1:0]      r_wr;
  logic [AW-1:0]      r_rd;
  logic [AW:0]        r_cnt;
  entry_t             r_last;

  // Fibonacci history
  logic [WIDTH-1:0]   r_fa;
  logic [WIDTH-1:0]   r_fb;
  logic [1:0]         r_fcnt;
  logic               r_ferr;

  logic [WIDTH-1:0]   w_tap [NUM_CH];
  logic [NUM_CH-1:0]  w_chg;
  logic               w_gnt_vld;
  logic [CW-1:0]      w_gnt_idx;
  logic [3:0]         w_ovf_add;
  logic [16:0]        w_ovf_sum;
  logic               w_push;
  logic               w_pop;
  entry_t             w_push_e;
  entry_t             w_head;
  logic [WIDTH-1:0]   w_fsum;

  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] p, input int i);
    int j;
    j = int'(p) + i;
    if (j >= NUM_CH) j = j - NUM_CH;
    return CW'(j);
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_tap[k] = i_tap_in[k*WIDTH +: WIDTH];
      w_chg[k] = i_capture_en && (w_tap[k] != r_prev[k]);
    end
  end

  // Round-robin grant, starting at r_ptr. Fullness is judged on the pre-pop count.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (r_cnt < L_DEPTH) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_gnt_vld && r_pend[rr_idx(r_ptr, i)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = rr_idx(r_ptr, i);
        end
      end
    end
  end

  // A change on a pending slot that is not being drained this cycle loses the old value.
  always_comb begin
    w_ovf_add = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_chg[k] && r_pend[k] && !(w_gnt_vld && (w_gnt_idx == CW'(k))))
        w_ovf_add = w_ovf_add + 4'd1;
    end
    w_ovf_sum = {1'b0, r_ovf} + {13'd0, w_ovf_add};
  end

  assign w_push         = w_gnt_vld;
  assign w_push_e.ch    = w_gnt_idx;
  assign w_push_e.data  = r_sdata[w_gnt_idx];
  assign w_push_e.stamp = r_sstamp[w_gnt_idx];
  assign w_pop          = (r_cnt != '0) && i_out_ready;
  assign w_head         = (r_cnt != '0) ? r_mem[r_rd] : r_last;
  assign w_fsum         = r_fa + r_fb;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend  <= '0;
      r_ptr   <= '0;
      r_stamp <= '0;
      r_ovf   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_prev[k]   <= '0;
        r_sdata[k]  <= '0;
        r_sstamp[k] <= '0;
      end
    end else begin
      r_stamp <= r_stamp + STAMP_W'(1);
      r_ovf   <= w_ovf_sum[16] ? 16'hFFFF : w_ovf_sum[15:0];
      if (w_gnt_vld)
        r_ptr <= (w_gnt_idx == CW'(NUM_CH-1)) ? '0 : w_gnt_idx + CW'(1);
      for (int k = 0; k < NUM_CH; k++) begin
        if (i_capture_en) r_prev[k] <= w_tap[k];
        // A new change reloads the slot even when it is granted this cycle.
        if (w_chg[k]) begin
          r_pend[k]   <= 1'b1;
          r_sdata[k]  <= w_tap[k];
          r_sstamp[k] <= r_stamp;
        end else if (w_gnt_vld && (w_gnt_idx == CW'(k))) begin
          r_pend[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= w_push_e;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_last <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_rd   <= r_rd + AW'(1);
        r_last <= r_mem[r_rd];
      end
      if (w_push && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  // Recurrence check runs on channel-0 FIFO writes; the first two writes only seed history.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fa   <= '0;
      r_fb   <= '0;
      r_fcnt <= '0;
      r_ferr <= 1'b0;
    end else if ((FIB_CHECK != 0) && w_push && (w_gnt_idx == '0)) begin
      if ((r_fcnt == 2'd2) && (w_push_e.data != w_fsum)) r_ferr <= 1'b1;
      r_fa <= r_fb;
      r_fb <= w_push_e.data;
      if (r_fcnt != 2'd2) r_fcnt <= r_fcnt + 2'd1;
    end
  end

  assign o_out_valid    = (r_cnt != '0);
  assign o_out_ch       = w_head.ch;
  assign o_out_data     = w_head.data;
  assign o_out_stamp    = w_head.stamp;
  assign o_fifo_count   = r_cnt;
  assign o_overflow_cnt = r_ovf;
  assign o_fib_err      = r_ferr;

endmodule

// File: tb/tb_reg_trace_capture.sv
// Purpose : directed bench for reg_trace_capture with hand-computed expectations.
// Latency : n/a (bench).
// Backpres: drives i_out_ready directly to exercise full-FIFO and drain behaviour.
module tb_reg_trace_capture;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] tap;
  logic         en;
  logic         ready;
  logic         valid;
  logic [1:0]   ch;
  logic [31:0]  data;
  logic [19:0]  stamp;
  logic [4:0]   count;
  logic [15:0]  ovf;
  logic         ferr;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int R = 0;
  int N = 0;

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic [19:0] stamp;
    int          edge_i;
  } rec_t;
  rec_t q[$];

  reg_trace_capture dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_tap_in       (tap),
    .i_capture_en   (en),
    .o_out_valid    (valid),
    .i_out_ready    (ready),
    .o_out_ch       (ch),
    .o_out_data     (data),
    .o_out_stamp    (stamp),
    .o_fifo_count   (count),
    .o_overflow_cnt (ovf),
    .o_fib_err      (ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Record every pop one half-cycle before the edge that performs it.
  always @(negedge clk) begin
    if (!rst && valid && ready)
      q.push_back('{int'(ch), data, stamp, edge_n + 1});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_tap(input int c, input logic [31:0] v);
    tap[c*32 +: 32] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    R = edge_n;
    rst = 1'b0;
    q.delete();
  endtask

  function automatic logic [19:0] exp_stamp(input int e);
    return 20'(e - R - 1);
  endfunction

  task automatic chk_entry(input string tag, input int i, input int c, input logic [31:0] d);
    if (i < q.size()) begin
      chk({tag, "_ch"}, 64'(q[i].ch), 64'(c));
      chk({tag, "_data"}, 64'(q[i].data), 64'(d));
    end else begin
      chk({tag, "_missing"}, 64'(q.size()), 64'(i + 1));
    end
  endtask

  int v1[5] = '{1, 2, 3, 5, 8};
  int v2[4] = '{1, 2, 4, 6};

  initial begin
    rst   = 1'b0;
    tap   = '0;
    en    = 1'b1;
    ready = 1'b1;

    // 1: Fibonacci run on ch0, one change per 4 cycles
    do_reset();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_ch",    64'(ch),    64'd0);
    chk("rst_data",  64'(data),  64'd0);
    chk("rst_stamp", 64'(stamp), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf",   64'(ovf),   64'd0);
    chk("rst_fib",   64'(ferr),  64'd0);
    for (int i = 0; i < 5; i++) begin
      set_tap(0, 32'(v1[i]));
      step();
      if (i == 0) begin
        N = edge_n;
        chk("lat_edgeN_valid", 64'(valid), 64'd0);
        step();
        chk("lat_edgeN1_valid", 64'(valid), 64'd1);
        chk("lat_edgeN1_data",  64'(data),  64'd1);
        step(2);
      end else begin
        step(3);
      end
    end
    step(6);
    chk("t1_size", 64'(q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk_entry("t1", i, 0, 32'(v1[i]));
      if (i < q.size()) chk("t1_stamp", 64'(q[i].stamp), 64'(exp_stamp(N + 4*i)));
    end
    chk("t1_fib", 64'(ferr), 64'd0);
    chk("t1_ovf", 64'(ovf),  64'd0);

    // 2: broken recurrence 1,2,4 then a correct 6; error is sticky until reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_tap(0, 32'(v2[i]));
      step(4);
      if (i == 1) chk("t2_fib_after2", 64'(ferr), 64'd0);
      if (i == 2) chk("t2_fib_after3", 64'(ferr), 64'd1);
    end
    chk("t2_fib_sticky", 64'(ferr), 64'd1);
    set_tap(0, 32'd0);
    do_reset();
    chk("t2_fib_cleared", 64'(ferr), 64'd0);

    // 3: all four channels change at the same edge
    step(2);
    do_reset();
    for (int k = 0; k < 4; k++) set_tap(k, 32'hA0 + 32'(k));
    step();
    N = edge_n;
    step(8);
    chk("t3_size", 64'(q.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk_entry("t3", k, k, 32'hA0 + 32'(k));
      if (k < q.size()) begin
        chk("t3_stamp", 64'(q[k].stamp), 64'(exp_stamp(N)));
        chk("t3_edge",  64'(q[k].edge_i), 64'(N + 2 + k));
      end
    end

    // 4: blocked consumer, 20 changes on ch1 two cycles apart
    tap = '0;
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_tap(1, 32'd100 + 32'(i));
      step(2);
    end
    step(2);
    chk("t4_count_full", 64'(count), 64'd16);
    chk("t4_ovf",        64'(ovf),   64'd3);
    ready = 1'b1;
    step(25);
    chk("t4_drain_size", 64'(q.size()), 64'd17);
    chk_entry("t4_first", 0, 1, 32'd100);
    chk_entry("t4_16th", 15, 1, 32'd115);
    chk_entry("t4_last", 16, 1, 32'd119);
    chk("t4_count_empty", 64'(count), 64'd0);
    chk("t4_hold_data",   64'(data),  64'd119);
    chk("t4_hold_ch",     64'(ch),    64'd1);

    // 5: capture disable freezes prev
    tap = '0;
    do_reset();
    chk("t5_rst_ovf", 64'(ovf), 64'd0);
    set_tap(2, 32'd5);
    step(3);
    chk("t5_first_size", 64'(q.size()), 64'd1);
    chk_entry("t5_first", 0, 2, 32'd5);
    en = 1'b0;
    set_tap(2, 32'd9); step(2);
    set_tap(2, 32'd3); step(2);
    chk("t5_dis_count", 64'(count), 64'd0);
    set_tap(2, 32'd5); step();
    en = 1'b1;
    step(4);
    chk("t5_reen_size", 64'(q.size()), 64'd1);
    set_tap(2, 32'd6);
    step(4);
    chk("t5_new_size", 64'(q.size()), 64'd2);
    chk_entry("t5_new", 1, 2, 32'd6);

    // 6: reset mid-occupancy
    tap = '0;
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_tap(0, 32'(v1[i]));
      step(2);
    end
    step(2);
    chk("t6_count5", 64'(count), 64'd5);
    rst = 1'b1;
    step();
    R = edge_n;
    chk("t6_rst_valid", 64'(valid), 64'd0);
    chk("t6_rst_ch",    64'(ch),    64'd0);
    chk("t6_rst_data",  64'(data),  64'd0);
    chk("t6_rst_stamp", 64'(stamp), 64'd0);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_ovf",   64'(ovf),   64'd0);
    chk("t6_rst_fib",   64'(ferr),  64'd0);
    rst = 1'b0;
    q.delete();
    ready = 1'b1;
    // ch0 still holds 8, which differs from the cleared prev: event at first edge, stamp 0.
    step(2);
    set_tap(0, 32'd13); step(2);
    set_tap(0, 32'd21); step(2);
    step(4);
    chk("t6_size", 64'(q.size()), 64'd3);
    chk_entry("t6_e0", 0, 0, 32'd8);
    if (q.size() > 0) chk("t6_stamp0", 64'(q[0].stamp), 64'd0);
    chk_entry("t6_e1", 1, 0, 32'd13);
    chk_entry("t6_e2", 2, 0, 32'd21);
    chk("t6_fib", 64'(ferr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
